serial_add_sequencer: RTL and testbench

SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

---
 rtl/serial_add_sequencer_pkg.sv | 12 +
 rtl/serial_add_sequencer_nibble_adder.sv | 24 ++
 rtl/serial_add_sequencer.sv | 108 ++++++++++
 tb/tb_serial_add_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sequencer_pkg.sv
// rtl/serial_add_sequencer_pkg.sv - shared constants and FSM encoding for the nibble-serial adder
package serial_add_sequencer_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_sequencer_nibble_adder.sv
// rtl/serial_add_sequencer_nibble_adder.sv - 4-bit ripple-carry adder slice
module nibble_adder
    import serial_add_sequencer_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             c_i,
    output logic [NIB_W-1:0] s_o,
    output logic             c_o
);

    logic c;

    always_comb begin
        c   = c_i;
        s_o = '0;
        for (int k = 0; k < NIB_W; k++) begin
            s_o[k] = a_i[k] ^ b_i[k] ^ c;
            c      = (a_i[k] & b_i[k]) | (c & (a_i[k] ^ b_i[k]));
        end
        c_o = c;
    end

endmodule

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - W-bit add/subtract computed one nibble per cycle on a shared slice
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIB_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy
);

    localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic [W-1:0]     sum_d;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;

    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] s_nib;
    logic             slice_co;

    // Operands shift right each RUN cycle, so the slice always sees the current nibble at the bottom.
    assign a_nib = a_q[NIB_W-1:0];
    assign b_nib = b_q[NIB_W-1:0];
    assign sum_d = (sum_q >> NIB_W) | (W'(s_nib) << (W - NIB_W));

    nibble_adder u_slice (
        .a_i (a_nib),
        .b_i (b_nib),
        .c_i (carry_q),
        .s_o (s_nib),
        .c_o (slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> NIB_W;
                    b_q     <= b_q >> NIB_W;
                    sum_q   <= sum_d;
                    carry_q <= slice_co;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // The last nibble holds the operand and result sign bits.
                        cout_q  <= slice_co;
                        ovf_q   <= (a_nib[NIB_W-1] == b_nib[NIB_W-1]) &&
                                   (s_nib[NIB_W-1] != a_nib[NIB_W-1]);
                        idx_q   <= '0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - randomized self-checking bench against an arithmetic reference model
module tb_serial_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        sub, cin, cout, ovf, busy;

    logic        n1_in_valid, n1_in_ready, n1_out_valid, n1_out_ready;
    logic [3:0]  n1_a, n1_b, n1_sum;
    logic        n1_sub, n1_cin, n1_cout, n1_ovf, n1_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_add_sequencer #(.NIBBLES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    serial_add_sequencer #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
        .a(n1_a), .b(n1_b), .sub(n1_sub), .cin(n1_cin),
        .out_valid(n1_out_valid), .out_ready(n1_out_ready),
        .sum(n1_sum), .cout(n1_cout), .ovf(n1_ovf), .busy(n1_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input logic tc, input int hold, input bit noise);
        logic [16:0] full;
        logic [15:0] exp_sum;
        logic        exp_cout, exp_ovf;
        int          sa, sb, r, lat;
        bit          got;
        sa = $signed(ta);
        sb = $signed(tb_v);
        if (ts) begin
            exp_sum  = ta - tb_v;
            exp_cout = (ta >= tb_v);
            r        = sa - sb;
        end else begin
            full     = {1'b0, ta} + {1'b0, tb_v} + {16'd0, tc};
            exp_sum  = full[15:0];
            exp_cout = full[16];
            r        = sa + sb + int'(tc);
        end
        exp_ovf = (r > 32767) || (r < -32768);

        check("idle_ready", in_ready, 1);
        a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 1;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (out_valid) begin
                got = 1;
            end else begin
                check("run_ready", in_ready, 0);
                if (noise) begin
                    in_valid = 1'($urandom_range(0, 1));
                    a = 16'($urandom); b = 16'($urandom);
                    sub = 1'($urandom); cin = 1'($urandom);
                end
                tick();
                lat++;
            end
        end
        check("latency", lat, 5);
        check("done_busy", busy, 1);
        check("done_ready", in_ready, 0);
        for (int h = 0; h <= hold; h++) begin
            check("sum", sum, exp_sum);
            check("cout", cout, exp_cout);
            check("ovf", ovf, exp_ovf);
            check("done_valid", out_valid, 1);
            if (h < hold) begin
                if (noise) begin
                    in_valid = 1'($urandom_range(0, 1));
                    a = 16'($urandom); b = 16'($urandom);
                end
                tick();
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_ready", in_ready, 1);
    endtask

    task automatic run_n1(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts, input logic tc);
        logic [4:0] full;
        logic [3:0] exp_sum;
        logic       exp_cout, exp_ovf;
        int         sa, sb, r;
        sa = (ta > 4'd7) ? int'(ta) - 16 : int'(ta);
        sb = (tb_v > 4'd7) ? int'(tb_v) - 16 : int'(tb_v);
        if (ts) begin
            exp_sum = ta - tb_v; exp_cout = (ta >= tb_v); r = sa - sb;
        end else begin
            full = {1'b0, ta} + {1'b0, tb_v} + {4'd0, tc};
            exp_sum = full[3:0]; exp_cout = full[4]; r = sa + sb + int'(tc);
        end
        exp_ovf = (r > 7) || (r < -8);
        n1_a = ta; n1_b = tb_v; n1_sub = ts; n1_cin = tc; n1_in_valid = 1'b1;
        tick();
        n1_in_valid = 1'b0;
        check("n1_run_valid", n1_out_valid, 0);
        tick();
        check("n1_valid", n1_out_valid, 1);
        check("n1_sum", n1_sum, exp_sum);
        check("n1_cout", n1_cout, exp_cout);
        check("n1_ovf", n1_ovf, exp_ovf);
        n1_out_ready = 1'b1;
        tick();
        n1_out_ready = 1'b0;
        check("n1_ready", n1_in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        n1_in_valid = 1'b0; n1_out_ready = 1'b0;
        n1_a = '0; n1_b = '0; n1_sub = 1'b0; n1_cin = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b1, 3, 1);

        for (int i = 0; i < 30; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Abort an operation in its second RUN cycle.
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", in_ready, 1);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_quiet", out_valid, 0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            run_n1(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
